// File: rtl/decode_queue_pkg.sv
// Shared constants for the decode queue: MIPS32 field codes, opgen codes,
// functional-unit classes and the queue entry payload.
package decode_queue_pkg;

   localparam int unsigned OPGEN_WIDTH = 6;
   localparam int unsigned UNIT_BUS    = 3;

   // Opgen codes
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_NOP   = 6'd0;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_ADD   = 6'd1;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_ADDU  = 6'd2;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SUB   = 6'd3;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SUBU  = 6'd4;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_AND   = 6'd5;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_OR    = 6'd6;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_XOR   = 6'd7;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_NOR   = 6'd8;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SLT   = 6'd9;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SLTU  = 6'd10;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SLL   = 6'd11;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SRL   = 6'd12;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SRA   = 6'd13;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SLLV  = 6'd14;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SRLV  = 6'd15;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SRAV  = 6'd16;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MULT  = 6'd17;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MULTU = 6'd18;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_DIV   = 6'd19;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_DIVU  = 6'd20;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MFHI  = 6'd21;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MFLO  = 6'd22;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MTHI  = 6'd23;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MTLO  = 6'd24;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MOVZ  = 6'd25;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MOVN  = 6'd26;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_JR    = 6'd27;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_JALR  = 6'd28;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_SYSC  = 6'd29;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BRK   = 6'd30;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MADD  = 6'd31;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MADDU = 6'd32;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MSUB  = 6'd33;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MSUBU = 6'd34;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MUL   = 6'd35;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_CLZ   = 6'd36;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_CLO   = 6'd37;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BEQ   = 6'd38;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BNE   = 6'd39;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BLTZ  = 6'd40;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BGEZ  = 6'd41;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BGTZ  = 6'd42;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_BLEZ  = 6'd43;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_J     = 6'd44;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_JAL   = 6'd45;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_MEM   = 6'd46;
   localparam logic [OPGEN_WIDTH-1:0] OPGEN_CP0   = 6'd47;

   // Functional-unit classes
   localparam logic [UNIT_BUS-1:0] UNIT_NONE = 3'd0;
   localparam logic [UNIT_BUS-1:0] UNIT_ALU  = 3'd1;
   localparam logic [UNIT_BUS-1:0] UNIT_MDU  = 3'd2;
   localparam logic [UNIT_BUS-1:0] UNIT_BRU  = 3'd3;
   localparam logic [UNIT_BUS-1:0] UNIT_LSU  = 3'd4;
   localparam logic [UNIT_BUS-1:0] UNIT_CP0  = 3'd5;
   localparam logic [UNIT_BUS-1:0] UNIT_SYS  = 3'd6;
   localparam logic [UNIT_BUS-1:0] UNIT_RI   = 3'd7;

   // Major opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_REGIMM   = 6'h01;
   localparam logic [5:0] OP_COP0     = 6'h10;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1c;

   // COP0 rs codes and ERET funct
   localparam logic [4:0] CP0_RS_MF  = 5'd0;
   localparam logic [4:0] CP0_RS_MT  = 5'd4;
   localparam logic [4:0] CP0_RS_CO  = 5'd16;
   localparam logic [5:0] FUNCT_ERET = 6'h18;

   // One buffered decode result
   typedef struct packed {
      logic [OPGEN_WIDTH-1:0] opgen;
      logic [UNIT_BUS-1:0]    unit;
      logic [31:0]            inst;
      logic [31:0]            pc;
   } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side enqueue and dispatch-side dequeue bus of the decode queue.
// master: fetch/dispatch side. slave: the queue.
interface decode_queue_if
   import decode_queue_pkg::*;
#(
   parameter int unsigned LANES = 2
);
   localparam int unsigned CNT_W = $clog2(LANES + 1);

   logic                         flush;
   logic [CNT_W-1:0]             in_count;
   logic [LANES*32-1:0]          in_inst;
   logic [LANES*32-1:0]          in_pc;
   logic                         in_ready;
   logic [CNT_W-1:0]             out_count;
   logic [CNT_W-1:0]             out_take;
   logic [LANES*OPGEN_WIDTH-1:0] out_opgen;
   logic [LANES*UNIT_BUS-1:0]    out_unit;
   logic [LANES*32-1:0]          out_inst;
   logic [LANES*32-1:0]          out_pc;

   modport master (
      output flush, in_count, in_inst, in_pc, out_take,
      input  in_ready, out_count, out_opgen, out_unit, out_inst, out_pc
   );

   modport slave (
      input  flush, in_count, in_inst, in_pc, out_take,
      output in_ready, out_count, out_opgen, out_unit, out_inst, out_pc
   );
endinterface

// File: rtl/decode_queue_decoder.sv
// inst_decoder: combinational MIPS32 decode of one instruction word.
// Ports: inst_i (32-bit word) -> opgen_o (opgen code), unit_o (unit class).
module inst_decoder
   import decode_queue_pkg::*;
(
   input  logic [31:0]            inst_i,
   output logic [OPGEN_WIDTH-1:0] opgen_o,
   output logic [UNIT_BUS-1:0]    unit_o
);
   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [5:0] funct;
   logic       unused_bits;

   assign op          = inst_i[31:26];
   assign rs          = inst_i[25:21];
   assign rt          = inst_i[20:16];
   assign funct       = inst_i[5:0];
   assign unused_bits = ^inst_i[15:6];

   // Default is reserved-instruction with NOP opgen; each legal encoding overrides.
   always_comb begin
      opgen_o = OPGEN_NOP;
      unit_o  = UNIT_RI;
      if (inst_i == 32'h0) begin
         unit_o = UNIT_NONE;
      end else begin
         case (op)
            OP_SPECIAL: begin
               case (funct)
                  6'h00: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLL};
                  6'h02: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SRL};
                  6'h03: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SRA};
                  6'h04: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLLV};
                  6'h06: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SRLV};
                  6'h07: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SRAV};
                  6'h08: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_JR};
                  6'h09: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_JALR};
                  6'h0a: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_MOVZ};
                  6'h0b: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_MOVN};
                  6'h0c: {unit_o, opgen_o} = {UNIT_SYS, OPGEN_SYSC};
                  6'h0d: {unit_o, opgen_o} = {UNIT_SYS, OPGEN_BRK};
                  6'h10: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_MFHI};
                  6'h11: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MTHI};
                  6'h12: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_MFLO};
                  6'h13: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MTLO};
                  6'h18: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MULT};
                  6'h19: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MULTU};
                  6'h1a: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_DIV};
                  6'h1b: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_DIVU};
                  6'h20: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_ADD};
                  6'h21: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_ADDU};
                  6'h22: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SUB};
                  6'h23: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SUBU};
                  6'h24: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_AND};
                  6'h25: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_OR};
                  6'h26: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_XOR};
                  6'h27: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_NOR};
                  6'h2a: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLT};
                  6'h2b: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLTU};
                  default: ;
               endcase
            end
            OP_SPECIAL2: begin
               case (funct)
                  6'h00: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MADD};
                  6'h01: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MADDU};
                  6'h02: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MUL};
                  6'h04: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MSUB};
                  6'h05: {unit_o, opgen_o} = {UNIT_MDU, OPGEN_MSUBU};
                  6'h20: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_CLZ};
                  6'h21: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_CLO};
                  default: ;
               endcase
            end
            OP_REGIMM: begin
               case (rt)
                  5'h00, 5'h10: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BLTZ};
                  5'h01, 5'h11: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BGEZ};
                  default: ;
               endcase
            end
            // COP0 is keyed on rs; ERET additionally needs its funct
            OP_COP0: begin
               if (rs == CP0_RS_MF || rs == CP0_RS_MT) begin
                  {unit_o, opgen_o} = {UNIT_CP0, OPGEN_CP0};
               end else if (rs == CP0_RS_CO && funct == FUNCT_ERET) begin
                  {unit_o, opgen_o} = {UNIT_SYS, OPGEN_NOP};
               end
            end
            6'h02: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_J};
            6'h03: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_JAL};
            6'h04: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BEQ};
            6'h05: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BNE};
            6'h06: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BLEZ};
            6'h07: {unit_o, opgen_o} = {UNIT_BRU, OPGEN_BGTZ};
            6'h08, 6'h09: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_ADD};
            6'h0a: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLT};
            6'h0b: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_SLTU};
            6'h0c: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_AND};
            6'h0d, 6'h0f: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_OR};
            6'h0e: {unit_o, opgen_o} = {UNIT_ALU, OPGEN_XOR};
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e:
               {unit_o, opgen_o} = {UNIT_LSU, OPGEN_MEM};
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: LANES-wide decode stage feeding a DEPTH-entry circular queue.
// Ports: clk, rst_n (async, active-low), q_if (slave): enqueue side
// flush/in_count/in_inst/in_pc/in_ready, dequeue side out_count/out_take/
// out_opgen/out_unit/out_inst/out_pc.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 8
)(
   input  logic          clk,
   input  logic          rst_n,
   decode_queue_if.slave q_if
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(LANES + 1);
   localparam int unsigned OW    = OPGEN_WIDTH;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] take_c, enq_c;
   logic             wr_en_c;

   entry_t           mem_q [DEPTH];
   logic [OW-1:0]    dec_opgen [LANES];
   logic [UNIT_BUS-1:0] dec_unit [LANES];

   logic [LANES*OW-1:0]       opgen_c;
   logic [LANES*UNIT_BUS-1:0] unit_c;
   logic [LANES*32-1:0]       inst_c, pc_c;

   // Per-lane decoders
   for (genvar i = 0; i < LANES; i++) begin : g_dec
      inst_decoder u_dec (
         .inst_i  (q_if.in_inst[32*i +: 32]),
         .opgen_o (dec_opgen[i]),
         .unit_o  (dec_unit[i])
      );
   end

   // Next-state: all-or-nothing enqueue, clamped dequeue, flush overrides both
   always_comb begin
      take_c  = (q_if.out_take > out_count_q) ? out_count_q : q_if.out_take;
      enq_c   = (q_if.in_count != '0 && in_ready_q) ? q_if.in_count : '0;
      wr_en_c = (enq_c != '0) && !q_if.flush;
      head_d  = head_q + PTR_W'(take_c);
      tail_d  = tail_q + PTR_W'(enq_c);
      count_d = count_q + CW'(enq_c) - CW'(take_c);
      if (q_if.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
      out_count_d = (count_d >= CW'(LANES)) ? CNT_W'(LANES) : CNT_W'(count_d);
      in_ready_d  = (CW'(DEPTH) - count_d) >= CW'(LANES);
   end

   // Pointer/status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_count_q <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         out_count_q <= out_count_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Payload storage; no reset needed since occupancy gates visibility
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < LANES; i++) begin
         if (wr_en_c && (CNT_W'(i) < q_if.in_count)) begin
            mem_q[tail_q + PTR_W'(i)] <= '{opgen: dec_opgen[i],
                                           unit:  dec_unit[i],
                                           inst:  q_if.in_inst[32*i +: 32],
                                           pc:    q_if.in_pc[32*i +: 32]};
         end
      end
   end

   // Presented slots: head-relative reads, unused slots forced to NOP/NONE
   for (genvar j = 0; j < LANES; j++) begin : g_rd
      entry_t e;
      logic   live;
      assign e    = mem_q[head_q + PTR_W'(j)];
      assign live = CNT_W'(j) < out_count_q;
      assign opgen_c[OW*j +: OW]             = live ? e.opgen : OPGEN_NOP;
      assign unit_c[UNIT_BUS*j +: UNIT_BUS]  = live ? e.unit  : UNIT_NONE;
      assign inst_c[32*j +: 32]              = e.inst;
      assign pc_c[32*j +: 32]                = e.pc;
   end

   assign q_if.in_ready  = in_ready_q;
   assign q_if.out_count = out_count_q;
   assign q_if.out_opgen = opgen_c;
   assign q_if.out_unit  = unit_c;
   assign q_if.out_inst  = inst_c;
   assign q_if.out_pc    = pc_c;

   // Dispatch must never consume more than is presented
   a_take_le_count: assert property (@(posedge clk) disable iff (!rst_n)
      q_if.out_take <= q_if.out_count);

endmodule
